instruction_fetch_unit: RTL

//  Fetch stage upstream of the jump/ALU decoders. During the FETCH phase, reads the word at PC_A over a

---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_timeout.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fstate_e        : fetch FSM state encoding (IDLE/BUS/DONE)
//   INSTRUCTION_NOP : instruction word substituted on reset, flush or bus timeout
//   timeout_cnt_w() : counter width needed to count up to LIMIT-1
package instruction_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W = 16;
  localparam int unsigned IFU_DATA_W = 16;

  localparam logic [IFU_DATA_W-1:0] INSTRUCTION_NOP = 16'h0000;

  typedef enum logic [1:0] {
    FSTATE_IDLE = 2'd0,
    FSTATE_BUS  = 2'd1,
    FSTATE_DONE = 2'd2
  } fstate_e;

  // Bits needed to hold 0..limit-1; limit is at least 2, so never below 1.
  function automatic int unsigned timeout_cnt_w(input int unsigned limit);
    return (limit <= 32'd2) ? 32'd1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_timeout.sv
// bus_timeout_counter: counts consecutive stalled bus cycles and flags expiry.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
//   CLK      : system clock, rising edge
//   RESET    : asynchronous active-high reset, count <= 0
//   CLEAR    : synchronous clear, asserted on entry to the bus state
//   COUNT_EN : a bus cycle with no ready response
//   EXPIRED  : combinational; this counting cycle is number LIMIT
module bus_timeout_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLEAR,
  input  logic COUNT_EN,
  output logic EXPIRED
);

  localparam int unsigned CNT_W = timeout_cnt_w(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 32'd1);

  logic [CNT_W-1:0] count_q;

  // Stalled-cycle counter; parks at LAST so it can never wrap.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (CLEAR) begin
      count_q <= '0;
    end else if (COUNT_EN && (count_q != LAST)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // count_q already holds LIMIT-1 earlier stalled cycles, so this one is the LIMIT-th.
  assign EXPIRED = COUNT_EN && (count_q == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage in front of the jump/ALU decoders.
// While FETCH is asserted, reads the word at PC_A over a wait-state memory
// handshake and latches it into INSTRUCTION, holding the phase sequencer via
// STALL until the word is captured. FLUSH substitutes NOP_INSTR.
// Optional feature macro: FETCH_TIMEOUT_EN (bus timeout with sticky BUS_ERR).
// Ports:
//   CLK, RESET        : clock (rising edge), asynchronous active-high reset
//   FETCH, PC_A       : fetch phase strobe and current program counter
//   FLUSH             : replace current/held instruction with NOP_INSTR
//   MEM_ADDR, MEM_RD  : registered fetch address, read request (BUS only)
//   MEM_DIN, MEM_READY: read data and completion handshake
//   INSTRUCTION       : instruction register to the decoders
//   IR_VALID          : INSTRUCTION holds a genuinely fetched word
//   STALL             : combinational hold of the phase decoder
//   BUS_ERR, BUS_ERR_CLR : sticky timeout flag and its synchronous clear
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W         = IFU_ADDR_W,
  parameter int unsigned          DATA_W         = IFU_DATA_W,
  parameter logic [DATA_W-1:0]    NOP_INSTR      = DATA_W'(INSTRUCTION_NOP),
  parameter int unsigned          TIMEOUT_CYCLES = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FETCH,
  input  logic [ADDR_W-1:0] PC_A,
  input  logic              FLUSH,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [DATA_W-1:0] MEM_DIN,
  input  logic              MEM_READY,
  output logic [DATA_W-1:0] INSTRUCTION,
  output logic              IR_VALID,
  output logic              STALL,
  output logic              BUS_ERR,
  input  logic              BUS_ERR_CLR
);

  fstate_e           state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  // Set when a flush hits an in-flight read, so its late data is dropped.
  logic              discard_q, discard_d;
  logic              expired;

  // State and datapath registers; reset also aborts any read in progress.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= FSTATE_IDLE;
      addr_q    <= '0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
    end
  end

  // Next-state and instruction-register update.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    discard_d = discard_q;

    case (state_q)
      FSTATE_IDLE: begin
        if (FETCH) begin
          state_d   = FSTATE_BUS;
          addr_d    = PC_A;
          valid_d   = 1'b0;
          discard_d = 1'b0;
        end
      end
      // A FETCH drop here is a sequencer error; the read completes regardless.
      FSTATE_BUS: begin
        if (MEM_READY) begin
          state_d = FSTATE_DONE;
          if (!discard_q) begin
            instr_d = MEM_DIN;
            valid_d = 1'b1;
          end
        end else if (expired) begin
          state_d = FSTATE_DONE;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      FSTATE_DONE: begin
        if (!FETCH) begin
          state_d = FSTATE_IDLE;
        end
      end
      default: begin
        state_d = FSTATE_IDLE;
      end
    endcase

    // Flush overrides any capture on the same edge, including a ready response.
    if (FLUSH) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (state_q == FSTATE_BUS) begin
        discard_d = 1'b1;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic err_q;

  bus_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK      (CLK),
    .RESET    (RESET),
    .CLEAR    ((state_q == FSTATE_IDLE) && FETCH),
    .COUNT_EN ((state_q == FSTATE_BUS) && !MEM_READY),
    .EXPIRED  (expired)
  );

  // Sticky error flag; a new timeout beats a clear on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if (expired) begin
      err_q <= 1'b1;
    end else if (BUS_ERR_CLR) begin
      err_q <= 1'b0;
    end
  end

  assign BUS_ERR = err_q;
`else
  // No timeout: the bus waits indefinitely and the error flag is constant.
  logic unused_timeout_cfg;

  assign expired            = 1'b0;
  assign BUS_ERR            = 1'b0;
  assign unused_timeout_cfg = ^{BUS_ERR_CLR, 8'(TIMEOUT_CYCLES)};
`endif

  assign MEM_ADDR    = addr_q;
  assign MEM_RD      = (state_q == FSTATE_BUS);
  assign INSTRUCTION = instr_q;
  assign IR_VALID    = valid_q;
  assign STALL       = FETCH && (state_q != FSTATE_DONE);

endmodule
